// File: rtl/lane_queue_counter.sv
// Four-lane vehicle queue counter: per-lane synchronized arrival detection,
// green-light timed departures, saturating 3-bit depth and sticky overflow.

module lqc_lane #(
    parameter int DEPART_PERIOD = 1
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       sensor,
    input  logic [2:0] st,
    output logic [2:0] count,
    output logic       overflow
);
    localparam logic [3:0] DWELL_LAST = 4'(DEPART_PERIOD - 1);

    logic       sync1, sync2, prev;
    logic [3:0] dwell;
    logic       green, arrival, departure;

    // Only the exact green code opens the lane; amber, red and illegal codes do not.
    assign green     = (st == 3'b001);
    assign arrival   = sync2 & ~prev;
    assign departure = green && (dwell == DWELL_LAST) && (count != 3'd0);

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            dwell    <= 4'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
            prev  <= sync2;

            // Dwell keeps running through an empty queue so departure timing
            // stays anchored to the start of green.
            if (!green || dwell == DWELL_LAST)
                dwell <= 4'd0;
            else
                dwell <= dwell + 4'd1;

            case ({arrival, departure})
                2'b10: begin
                    if (count == 3'd7)
                        overflow <= 1'b1;
                    else
                        count <= count + 3'd1;
                end
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

module lane_queue_counter #(
    parameter int DEPART_PERIOD = 1
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       sensor_A,
    input  logic       sensor_B,
    input  logic       sensor_C,
    input  logic       sensor_D,
    input  logic [2:0] st_A,
    input  logic [2:0] st_B,
    input  logic [2:0] st_C,
    input  logic [2:0] st_D,
    output logic [2:0] count1,
    output logic [2:0] count2,
    output logic [2:0] count3,
    output logic [2:0] count4,
    output logic [3:0] overflow
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]      sensor_v;
    logic [NUM_LANES-1:0][2:0] st_v;
    logic [NUM_LANES-1:0][2:0] count_v;

    assign sensor_v = {sensor_D, sensor_C, sensor_B, sensor_A};
    assign st_v     = {st_D, st_C, st_B, st_A};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lqc_lane #(
            .DEPART_PERIOD(DEPART_PERIOD)
        ) u_lane (
            .clk_1Hz (clk_1Hz),
            .reset   (reset),
            .sensor  (sensor_v[i]),
            .st      (st_v[i]),
            .count   (count_v[i]),
            .overflow(overflow[i])
        );
    end

    assign count1 = count_v[0];
    assign count2 = count_v[1];
    assign count3 = count_v[2];
    assign count4 = count_v[3];
endmodule

// File: tb/tb_lane_queue_counter.sv
// Bench for lane_queue_counter: two instances (DEPART_PERIOD 1 and 2) checked
// every cycle against a queue-level model, plus directed literal expectations.

module tb_lane_queue_counter;
    logic            clk_1Hz = 1'b0;
    logic            reset   = 1'b1;
    logic [3:0]      sensor  = 4'h0;
    logic [3:0][2:0] st      = {4{3'b100}};
    logic [3:0][2:0] cnt_a, cnt_b;
    logic [3:0]      ovf_a, ovf_b;

    int errors = 0;
    int checks = 0;

    // Model state: last three sensor samples per lane, green-run length per
    // lane, and per-instance queue depth / overflow.
    bit h1[4], h2[4], h3[4];
    int grun[4];
    int mcnt[2][4];
    bit movf[2][4];
    int per[2] = '{1, 2};

    always #5 clk_1Hz = ~clk_1Hz;

    lane_queue_counter #(.DEPART_PERIOD(1)) u_dut1 (
        .clk_1Hz(clk_1Hz), .reset(reset),
        .sensor_A(sensor[0]), .sensor_B(sensor[1]), .sensor_C(sensor[2]), .sensor_D(sensor[3]),
        .st_A(st[0]), .st_B(st[1]), .st_C(st[2]), .st_D(st[3]),
        .count1(cnt_a[0]), .count2(cnt_a[1]), .count3(cnt_a[2]), .count4(cnt_a[3]),
        .overflow(ovf_a)
    );

    lane_queue_counter #(.DEPART_PERIOD(2)) u_dut2 (
        .clk_1Hz(clk_1Hz), .reset(reset),
        .sensor_A(sensor[0]), .sensor_B(sensor[1]), .sensor_C(sensor[2]), .sensor_D(sensor[3]),
        .st_A(st[0]), .st_B(st[1]), .st_C(st[2]), .st_D(st[3]),
        .count1(cnt_b[0]), .count2(cnt_b[1]), .count3(cnt_b[2]), .count4(cnt_b[3]),
        .overflow(ovf_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 4; l++) begin
            h1[l] = 0; h2[l] = 0; h3[l] = 0; grun[l] = 0;
            for (int d = 0; d < 2; d++) begin
                mcnt[d][l] = 0;
                movf[d][l] = 0;
            end
        end
    endtask

    // One clock edge: an arrival is a 0->1 step in the sensor samples taken
    // two and three edges ago; departures fall on every per-th green edge.
    task automatic model_step();
        for (int l = 0; l < 4; l++) begin
            bit arr, dep;
            arr = h2[l] && !h3[l];
            h3[l] = h2[l]; h2[l] = h1[l]; h1[l] = sensor[l];
            grun[l] = (st[l] == 3'b001) ? grun[l] + 1 : 0;
            for (int d = 0; d < 2; d++) begin
                dep = (grun[l] != 0) && (grun[l] % per[d] == 0) && (mcnt[d][l] != 0);
                if (arr && !dep) begin
                    if (mcnt[d][l] == 7) movf[d][l] = 1;
                    else mcnt[d][l]++;
                end else if (dep && !arr) begin
                    mcnt[d][l]--;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_1Hz);
        if (!reset) model_step();
        #2;
    endtask

    task automatic pulse(input logic [3:0] mask);
        sensor = sensor | mask;
        tick(); tick();
        sensor = sensor & ~mask;
        tick(); tick();
    endtask

    always @(negedge clk_1Hz) begin
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("cnt_p1_lane%0d", l), int'(cnt_a[l]), mcnt[0][l]);
            chk($sformatf("cnt_p2_lane%0d", l), int'(cnt_b[l]), mcnt[1][l]);
            chk($sformatf("ovf_p1_lane%0d", l), int'(ovf_a[l]), int'(movf[0][l]));
            chk($sformatf("ovf_p2_lane%0d", l), int'(ovf_b[l]), int'(movf[1][l]));
        end
    end

    initial begin
        model_clear();
        tick(); tick();
        chk("reset_cnt_p1", int'(cnt_a), 0);
        chk("reset_ovf_p1", int'(ovf_a), 0);
        reset = 1'b0;
        tick();

        // Basic latency on lane A.
        sensor[0] = 1'b1;
        tick(); tick();
        chk("lat_before_e2", int'(cnt_a[0]), 0);
        sensor[0] = 1'b0;
        tick();
        chk("lat_e2_cnt1", int'(cnt_a[0]), 1);
        chk("lat_e2_others", int'({cnt_a[3], cnt_a[2], cnt_a[1]}), 0);
        tick();

        // Saturation on lane B.
        for (int k = 1; k <= 9; k++) begin
            pulse(4'b0010);
            chk($sformatf("sat_cnt2_p%0d", k), int'(cnt_a[1]), (k < 7) ? k : 7);
            chk($sformatf("sat_ovf_p%0d", k), int'(ovf_a), (k >= 8) ? 4'b0010 : 4'b0000);
        end

        // Drain lane C at period 2.
        for (int k = 0; k < 3; k++) pulse(4'b0100);
        chk("drain_start", int'(cnt_b[2]), 3);
        st[2] = 3'b001;
        for (int g = 1; g <= 8; g++) begin
            tick();
            chk($sformatf("drain_g%0d", g), int'(cnt_b[2]), (g >= 6) ? 0 : 3 - g / 2);
        end
        st[2] = 3'b100;
        chk("drain_p1_empty", int'(cnt_a[2]), 0);

        // Arrival and departure on the same edge, lane D, period 1.
        for (int k = 0; k < 4; k++) pulse(4'b1000);
        chk("simul_start", int'(cnt_a[3]), 4);
        sensor[3] = 1'b1;
        tick(); tick();
        st[3] = 3'b001;
        tick();
        chk("simul_cnt4", int'(cnt_a[3]), 4);
        chk("simul_cnt4_p2", int'(cnt_b[3]), 5);
        st[3] = 3'b100;
        sensor[3] = 1'b0;
        tick(); tick();

        // Amber and illegal codes never release a vehicle.
        for (int k = 0; k < 4; k++) pulse(4'b0001);
        st[0] = 3'b010;
        for (int k = 0; k < 4; k++) tick();
        chk("amber_cnt1", int'(cnt_a[0]), 5);
        st[0] = 3'b011;
        for (int k = 0; k < 4; k++) tick();
        chk("illegal_cnt1", int'(cnt_a[0]), 5);
        st[0] = 3'b001;
        tick();
        chk("green_g1_p2", int'(cnt_b[0]), 5);
        tick();
        chk("green_g2_p2", int'(cnt_b[0]), 4);
        st[0] = 3'b100;

        // Fill every lane past saturation at once, then async reset.
        for (int k = 0; k < 8; k++) pulse(4'hF);
        st[0] = 3'b001;
        tick();
        st[0] = 3'b100;
        chk("pre_rst_cnt1", int'(cnt_a[0]), 6);
        chk("pre_rst_ovf", int'(ovf_a), 4'hF);
        chk("pre_rst_ovf_p2", int'(ovf_b), 4'hF);
        reset = 1'b1;
        #1;
        chk("async_rst_cnt_p1", int'(cnt_a), 0);
        chk("async_rst_cnt_p2", int'(cnt_b), 0);
        chk("async_rst_ovf", int'({ovf_b, ovf_a}), 0);
        model_clear();
        #1;
        reset = 1'b0;

        // Randomized traffic with arbitrary light codes and occasional resets.
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 2) == 0) sensor[l] = ~sensor[l];
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 5))
                        0, 1: st[l] = 3'b001;
                        2:    st[l] = 3'b010;
                        3:    st[l] = 3'b100;
                        4:    st[l] = 3'b000;
                        default: st[l] = 3'($urandom_range(0, 7));
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_clear();
                #1;
                reset = 1'b0;
            end
        end
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lane_queue_counter.md
LANE_QUEUE_COUNTER -- requirements
Module: lane_queue_counter

Interface
REQ-001 The block SHALL have parameter DEPART_PERIOD, default 1, giving the number of green-light clock cycles per vehicle departure (legal range 1..15).
REQ-002 The block SHALL have port clk_1Hz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports sensor_A, sensor_B, sensor_C, sensor_D, inputs, 1 bit each: asynchronous vehicle-presence level per lane.
REQ-005 The block SHALL have ports st_A, st_B, st_C, st_D, inputs, 3 bits each: the lane light state, coded 3'b001 green, 3'b010 amber, 3'b100 red.
REQ-006 The block SHALL have ports count1, count2, count3, count4, outputs, 3 bits each: registered queue depth of lanes A, B, C and D respectively.
REQ-007 The block SHALL have port overflow, output, 4 bits: sticky per-lane saturation flag, bit 0 = A through bit 3 = D.

Function
REQ-008 Per lane, the block SHALL pass sensor through a two-flop synchronizer (sync1, sync2) and then a previous-value flop (prev).
REQ-009 An arrival SHALL be the condition sync2 high and prev low, i.e. one arrival per sensor rising edge.
REQ-010 Latency: for a sensor rising edge before clock edge E0, the count SHALL update at edge E0+2.
REQ-011 Sensor pulses shorter than one clock period need not be counted.
REQ-012 A lane SHALL be green only when its st input equals exactly 3'b001; every other code (amber, red, 000, illegal) SHALL count as not green.
REQ-013 Per lane, a 4-bit dwell counter SHALL clear to 0 on any edge where the lane is not green.
REQ-014 While the lane is green, the dwell counter SHALL increment on each edge and wrap to 0 after reaching DEPART_PERIOD-1.
REQ-015 A departure SHALL be the condition: lane green, dwell counter equal to DEPART_PERIOD-1, and count nonzero.
REQ-016 With DEPART_PERIOD=1, the first departure SHALL occur on the first edge at which the lane's st input reads 3'b001.
REQ-017 Count update, arrival only: count SHALL increment, saturating at 7.
REQ-018 Count update, departure only: count SHALL decrement, never below 0.
REQ-019 Count update, arrival and departure on the same edge: count SHALL be unchanged.
REQ-020 Count update, neither event: count SHALL hold.
REQ-021 An arrival with count already 7 and no departure SHALL set that lane's overflow bit, and the count SHALL stay 7.
REQ-022 Overflow bits SHALL clear only on reset.
REQ-023 A departure request with count 0 SHALL be ignored, and the dwell counter SHALL still advance or wrap normally.
REQ-024 Lanes SHALL be fully independent; simultaneous events on all four lanes SHALL be handled on the same edge.
REQ-025 A change of an st input SHALL take effect on the first edge at which the new value is sampled; there SHALL be no synchronizer on st inputs.

Reset
REQ-026 On reset assertion, count1..count4, overflow, all synchronizer flops, all prev flops and all dwell counters SHALL go to 0 immediately, without waiting for a clock edge.
REQ-027 While reset is high, no state SHALL change.
REQ-028 After reset deasserts, a sensor already high SHALL not produce an arrival until prev has first been seen low.
REQ-029 Reset asserted mid-operation SHALL discard all pending arrivals and queue contents.

Verification
REQ-030 The bench SHALL cover basic latency: lane A red, sensor_A pulsed high for 2 cycles rising before edge 0 -> count1 = 1 at edge 2, other counts 0.
REQ-031 The bench SHALL cover saturation: lane B red, 9 separate sensor_B pulses -> count2 reaches 7 on the 7th arrival and stays 7; overflow = 4'b0010 after the 8th arrival.
REQ-032 The bench SHALL cover drain: count3 = 3, DEPART_PERIOD=2, st_C set to 3'b001 -> count3 decrements at the 2nd, 4th and 6th green edges to 0, then holds 0 with no underflow.
REQ-033 The bench SHALL cover the simultaneous case: lane D green, DEPART_PERIOD=1, count4 = 4, arrival on the same edge as a departure -> count4 stays 4.
REQ-034 The bench SHALL cover amber/illegal codes: st_A = 3'b010, then 3'b011, with count1 = 5 -> no departures; dwell counter stays 0; count1 stays 5.
REQ-035 The bench SHALL cover async reset: reset pulsed between clock edges with count1 = 6 and overflow = 4'b1111 -> all counts and overflow read 0 before the next edge.
